count_sequencer: RTL and testbench

//   Controller that sequences the 4-bit counter datapath. Drives the counter's step-enable
//   and clear from button pulses (edge-detector outputs) and an internal auto-step prescaler.

---
 rtl/count_sequencer_if.sv | 23 ++
 rtl/count_sequencer.sv | 121 ++++++++++++
 tb/tb_count_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Handshake bundle between the button edge detectors, the counter and count_sequencer.
// Ports: step_req, mode_req, count (to sequencer); cnt_en, cnt_clr, state, done (from it).
interface count_sequencer_if #(
    parameter int CW = 4
);
    logic          step_req;
    logic          mode_req;
    logic [CW-1:0] count;
    logic          cnt_en;
    logic          cnt_clr;
    logic [1:0]    state;
    logic          done;

    modport master (
        output step_req, mode_req, count,
        input  cnt_en, cnt_clr, state, done
    );

    modport slave (
        input  step_req, mode_req, count,
        output cnt_en, cnt_clr, state, done
    );
endinterface

// File: rtl/count_sequencer.sv
// Sequencer for the 4-bit counter: MANUAL / AUTO / PAUSE / DONE with auto-step prescaler.
// Ports: clk, rst (sync, active high), bus (slave: step_req, mode_req, count in;
// cnt_en, cnt_clr, state, done out). Macro SEQ_STOP_AT_LIMIT_EN: stop in DONE at LIMIT.
module count_sequencer #(
    parameter int CW       = 4,
    parameter int TICK_DIV = 8,
    parameter int LIMIT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    count_sequencer_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LIMIT_V   = CW'(LIMIT);

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        PAUSE  = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q, presc_n;
    logic          en_q, en_n;
    logic          clr_q, clr_n;
    logic          done_q;
    logic          tick;

    assign tick = (state_q == AUTO) && (presc_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            presc_q <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            presc_q <= presc_n;
            en_q    <= en_n;
            clr_q   <= clr_n;
            done_q  <= (state_n == DONE);
        end
    end

    // Requests take priority over the auto tick; mode_req beats step_req.
    always_comb begin
        state_n = state_q;
        presc_n = presc_q;
        en_n    = 1'b0;
        clr_n   = 1'b0;
        unique case (state_q)
            MANUAL: begin
                presc_n = '0;
                if (bus.mode_req) begin
                    state_n = AUTO;
                end else if (bus.step_req) begin
                    en_n = 1'b1;
                end
            end
            AUTO: begin
                if (bus.mode_req) begin
                    state_n = MANUAL;
                    presc_n = '0;
                end else if (bus.step_req) begin
                    // prescaler holds so a resume continues the interval
                    state_n = PAUSE;
                end else if (tick) begin
                    presc_n = '0;
                    if (bus.count != LIMIT_V) begin
                        en_n = 1'b1;
                    end else begin
`ifdef SEQ_STOP_AT_LIMIT_EN
                        state_n = DONE;
`else
                        clr_n = 1'b1;
`endif
                    end
                end else begin
                    presc_n = presc_q + PW'(1);
                end
            end
            PAUSE: begin
                if (bus.mode_req) begin
                    state_n = MANUAL;
                    presc_n = '0;
                end else if (bus.step_req) begin
                    state_n = AUTO;
                end
            end
            DONE: begin
                presc_n = '0;
                if (bus.mode_req) begin
                    state_n = MANUAL;
                end else if (bus.step_req) begin
                    clr_n   = 1'b1;
                    state_n = AUTO;
                end
            end
            default: begin
                state_n = MANUAL;
                presc_n = '0;
            end
        endcase
    end

    assign bus.cnt_en  = en_q;
    assign bus.cnt_clr = clr_q;
    assign bus.state   = state_q;
`ifdef SEQ_STOP_AT_LIMIT_EN
    assign bus.done    = done_q;
`else
    // DONE cannot be entered in this build
    assign bus.done    = 1'b0;
    logic unused_done;
    assign unused_done = done_q;
`endif
endmodule

// File: tb/tb_count_sequencer.sv
// Randomised and directed bench for count_sequencer (CW=4, TICK_DIV=4, LIMIT=15).
// Outputs are checked each cycle against a behavioural mode/interval model.
module tb_count_sequencer;
    localparam int TD  = 4;
    localparam int LIM = 15;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // model: mode 0 manual, 1 auto, 2 pause, 3 done; phase = cycles into interval
    int   m_mode;
    int   m_phase;
    bit   m_en;
    bit   m_clr;

    count_sequencer_if #(.CW(4)) bus ();

    count_sequencer #(.CW(4), .TICK_DIV(TD), .LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {bus.state, bus.cnt_en, bus.cnt_clr, bus.done};
    endfunction

    function automatic logic [4:0] expv();
        logic [1:0] st;
        st = m_mode[1:0];
        return {st, m_en, m_clr, (m_mode == 3)};
    endfunction

    task automatic model(input logic r, s, m, input int c);
        bit due;
        m_en  = 0;
        m_clr = 0;
        if (r) begin
            m_mode  = 0;
            m_phase = 0;
            return;
        end
        due = (m_mode == 1) && (m_phase == TD - 1);
        if (m) begin
            m_mode  = (m_mode == 0) ? 1 : 0;
            m_phase = 0;
        end else if (s) begin
            if (m_mode == 0) m_en = 1;
            else if (m_mode == 1) m_mode = 2;
            else if (m_mode == 2) m_mode = 1;
            else begin
                m_clr   = 1;
                m_mode  = 1;
                m_phase = 0;
            end
        end else if (m_mode == 1) begin
            if (!due) m_phase++;
            else begin
                m_phase = 0;
                if (c != LIM) m_en = 1;
`ifdef SEQ_STOP_AT_LIMIT_EN
                else m_mode = 3;
`else
                else m_clr = 1;
`endif
            end
        end
    endtask

    task automatic drive(input logic r, s, m, input logic [3:0] c);
        rst          = r;
        bus.step_req = s;
        bus.mode_req = m;
        bus.count    = c;
        @(posedge clk);
        model(r, s, m, int'(c));
        #1;
        rst          = 1'b0;
        bus.step_req = 1'b0;
        bus.mode_req = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 4'd0);
        drive(1, 0, 1, 4'd0);
        vectors++;
        if (obs() !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_init: got %b want %b", obs(), 5'b00000);
        end
        drive(0, 0, 1, 4'd3);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 4'd3);
        drive(1, 0, 0, 4'd3);
        drive(1, 1, 0, 4'd3);
        vectors++;
        if (obs() !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_mid_auto: got %b want %b", obs(), 5'b00000);
        end
        drive(0, 0, 0, 4'd3);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_after: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_manual();
        logic [4:0] seen [4];
        drive(0, 1, 0, 4'd5);
        seen[0] = obs();
        drive(0, 0, 0, 4'd6);
        seen[1] = obs();
        drive(0, 1, 0, 4'd15);
        seen[2] = obs();
        drive(0, 0, 0, 4'd0);
        seen[3] = obs();
        for (int i = 0; i < 4; i++) begin
            logic [4:0] w;
            w = (i % 2 == 0) ? 5'b00100 : 5'b00000;
            vectors++;
            if (seen[i] !== w) begin
                miscompares++;
                $display("FAIL manual_step[%0d]: got %b want %b", i, seen[i], w);
            end
        end
    endtask

    task automatic test_auto();
        int k;
        drive(0, 0, 1, 4'd3);
        vectors++;
        if (obs() !== 5'b01000) begin
            miscompares++;
            $display("FAIL auto_entry: got %b want %b", obs(), 5'b01000);
        end
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            drive(0, 0, 0, 4'd3);
            if (bus.cnt_en === 1'b1) k = i;
        end
        vectors++;
        if (k != TD) begin
            miscompares++;
            $display("FAIL auto_first_step: got %0d cycles want %0d", k, TD);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 4'd3);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL auto_period[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_pause();
        int k;
        int guard;
        guard = 0;
        while (!(m_mode == 1 && m_phase == 2) && guard < 10) begin
            drive(0, 0, 0, 4'd3);
            guard++;
        end
        drive(0, 1, 0, 4'd3);
        vectors++;
        if (obs() !== 5'b10000) begin
            miscompares++;
            $display("FAIL pause_enter: got %b want %b", obs(), 5'b10000);
        end
        k = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 4'd3);
            if (bus.cnt_en !== 1'b0) k++;
        end
        vectors++;
        if (k != 0) begin
            miscompares++;
            $display("FAIL pause_hold: got %0d steps want 0", k);
        end
        drive(0, 1, 0, 4'd3);
        k = 0;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            drive(0, 0, 0, 4'd3);
            if (bus.cnt_en === 1'b1) k = i;
        end
        vectors++;
        if (k != 2) begin
            miscompares++;
            $display("FAIL pause_resume: got %0d cycles want 2", k);
        end
    endtask

    task automatic test_limit();
        int guard;
        guard = 0;
        while (bus.state !== 2'b01 && guard < 4) begin
            drive(0, 0, 1, 4'd15);
            guard++;
        end
        guard = 0;
`ifdef SEQ_STOP_AT_LIMIT_EN
        while (bus.done !== 1'b1 && guard < 10) begin
            drive(0, 0, 0, 4'd15);
            guard++;
        end
        vectors++;
        if (obs() !== 5'b11001) begin
            miscompares++;
            $display("FAIL limit_done: got %b want %b", obs(), 5'b11001);
        end
        drive(0, 1, 0, 4'd15);
        vectors++;
        if (obs() !== 5'b01010) begin
            miscompares++;
            $display("FAIL done_restart: got %b want %b", obs(), 5'b01010);
        end
`else
        while (bus.cnt_clr !== 1'b1 && guard < 10) begin
            drive(0, 0, 0, 4'd15);
            guard++;
        end
        vectors++;
        if (obs() !== 5'b01010) begin
            miscompares++;
            $display("FAIL limit_clear: got %b want %b", obs(), 5'b01010);
        end
`endif
        drive(0, 1, 1, 4'd15);
        vectors++;
        if (obs() !== 5'b00000) begin
            miscompares++;
            $display("FAIL both_req: got %b want %b", obs(), 5'b00000);
        end
    endtask

    task automatic test_random();
        logic       r, s, m;
        logic [3:0] c;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 7) == 0);
            m = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            drive(r, s, m, c);
            vectors++;
            if (obs() !== expv() || (bus.cnt_en && bus.cnt_clr)) begin
                miscompares++;
                $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.step_req = 1'b0;
        bus.mode_req = 1'b0;
        bus.count    = 4'd0;
        m_mode       = 0;
        m_phase      = 0;
        m_en         = 0;
        m_clr        = 0;
        test_reset();
        test_manual();
        test_auto();
        test_pause();
        test_limit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
